// File: rtl/fifo_to_axi.sv
// fifo_to_axi: reassembles 192-bit FIFO payload words into 256-bit AXI4-Stream beats.
// A beat is built from up to four phases: phase 0 primes a residue, and phases 1..3 complete beats.
// The phase sequence is checked. A word out of sequence is dropped, and sync_err is set and held.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   din, din_valid      packed FIFO word {payload, cnt, phase, last, new} and its valid
//   rinc                pop strobe (combinational, asserted only with din_valid)
//   m_t*                AXI4-Stream master (tvalid/tready/tdata/tstrb/tkeep/tlast)
//   sync_err            sticky phase-mismatch flag
//   beat_cnt, pkt_cnt   wrapping counts of accepted beats / accepted last beats

package fifo_to_axi_pkg;

    localparam int unsigned PAYLOAD_W = 192;
    localparam int unsigned BCNT_W    = 5;

    // FIFO word layout, LSB first: new, last, phase, cnt, payload.
    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [BCNT_W-1:0]    cnt;
        logic [1:0]           phase;
        logic                 last;
        logic                 is_new;
    } fifo_word_t;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_e;

endpackage

module fifo_to_axi
    import fifo_to_axi_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned FIFO_WIDTH  = 201,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [FIFO_WIDTH-1:0]    din,
    input  logic                     din_valid,
    output logic                     rinc,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [TDATA_WIDTH*8-1:0] m_tdata,
    output logic [TDATA_WIDTH-1:0]   m_tstrb,
    output logic [TDATA_WIDTH-1:0]   m_tkeep,
    output logic                     m_tlast,
    output logic                     sync_err,
    output logic [CNT_WIDTH-1:0]     beat_cnt,
    output logic [CNT_WIDTH-1:0]     pkt_cnt
);

    localparam int unsigned DATA_W = TDATA_WIDTH * 8;

    fifo_word_t word;

    phase_e                 exp_phase_q, exp_phase_d;
    logic [PAYLOAD_W-1:0]   residue_q, residue_d;
    logic                   sync_err_q, sync_err_d;
    logic                   tvalid_q, tvalid_d;
    logic [DATA_W-1:0]      tdata_q, tdata_d;
    logic [TDATA_WIDTH-1:0] tstrb_q, tstrb_d;
    logic                   tlast_q, tlast_d;
    logic [CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;

    logic                   pop_c;
    logic                   emit_c;
    logic [DATA_W-1:0]      beat_c;
    logic [TDATA_WIDTH-1:0] strb_c;
    logic                   fire_c;

    assign word = fifo_word_t'(din);

    // Pop whenever the output register is free or draining this cycle.
    assign pop_c  = ~reset & din_valid & (~tvalid_q | m_tready);
    assign fire_c = tvalid_q & m_tready;

    // A cnt of 0 means a full beat. Otherwise only the low cnt bytes are valid.
    assign strb_c = (word.cnt == '0) ? {TDATA_WIDTH{1'b1}}
                                     : ~({TDATA_WIDTH{1'b1}} << word.cnt);

    // State register: phase tracker, residue, output beat and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_phase_q <= PH0;
            residue_q   <= '0;
            sync_err_q  <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tstrb_q     <= '0;
            tlast_q     <= 1'b0;
            beat_cnt_q  <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            exp_phase_q <= exp_phase_d;
            residue_q   <= residue_d;
            sync_err_q  <= sync_err_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tstrb_q     <= tstrb_d;
            tlast_q     <= tlast_d;
            beat_cnt_q  <= beat_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    // Next-state: phase sequencing, beat assembly, output handshake, counters.
    always_comb begin
        exp_phase_d = exp_phase_q;
        residue_d   = residue_q;
        sync_err_d  = sync_err_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        tstrb_d     = tstrb_q;
        tlast_d     = tlast_q;
        beat_cnt_d  = beat_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        emit_c      = 1'b0;
        beat_c      = '0;

        if (pop_c) begin
            // A mismatched phase, or a phase-0 word without new, resynchronises to phase 0.
            // Words are then dropped until a clean phase-0 start arrives.
            if ((word.phase != exp_phase_q) || ((word.phase == PH0) && !word.is_new)) begin
                sync_err_d  = 1'b1;
                exp_phase_d = PH0;
            end else begin
                unique case (exp_phase_q)
                    PH0: begin
                        residue_d   = word.payload;
                        exp_phase_d = PH1;
                    end
                    PH1: begin
                        emit_c = 1'b1;
                        beat_c = {word.payload[63:0], residue_q};
                        if (word.is_new) begin
                            residue_d[127:0] = word.payload[191:64];
                            exp_phase_d      = PH2;
                        end else begin
                            exp_phase_d = PH0;
                        end
                    end
                    PH2: begin
                        emit_c = 1'b1;
                        beat_c = {word.payload[127:0], residue_q[127:0]};
                        if (word.is_new) begin
                            residue_d[63:0] = word.payload[191:128];
                            exp_phase_d     = PH3;
                        end else begin
                            exp_phase_d = PH0;
                        end
                    end
                    PH3: begin
                        emit_c      = 1'b1;
                        beat_c      = {word.payload, residue_q[63:0]};
                        exp_phase_d = PH0;
                    end
                    default: exp_phase_d = PH0;
                endcase
            end
        end

        // The held beat drains on ready. A new beat in the same cycle replaces it without a bubble.
        if (m_tready) begin
            tvalid_d = 1'b0;
        end
        if (emit_c) begin
            tvalid_d = 1'b1;
            tdata_d  = beat_c;
            tstrb_d  = strb_c;
            tlast_d  = word.last;
        end

        if (fire_c) begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
            if (tlast_q) begin
                pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign rinc     = pop_c;
    assign m_tvalid = tvalid_q;
    assign m_tdata  = tdata_q;
    assign m_tstrb  = tstrb_q;
    assign m_tkeep  = tstrb_q;
    assign m_tlast  = tlast_q;
    assign sync_err = sync_err_q;
    assign beat_cnt = beat_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_fifo_to_axi.sv
// tb_fifo_to_axi: directed vectors for fifo_to_axi with hand-derived expected beats.
// The design is instantiated with CNT_WIDTH=4, so counter wrap is reachable in a short run.

module tb_fifo_to_axi;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset;
    logic [200:0]  din;
    logic          din_valid;
    logic          rinc;
    logic          m_tvalid;
    logic          m_tready;
    logic [255:0]  m_tdata;
    logic [31:0]   m_tstrb;
    logic [31:0]   m_tkeep;
    logic          m_tlast;
    logic          sync_err;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] pkt_cnt;

    int n_vec;
    int n_err;

    fifo_to_axi #(
        .TDATA_WIDTH (32),
        .FIFO_WIDTH  (201),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .rinc      (rinc),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tstrb   (m_tstrb),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .sync_err  (sync_err),
        .beat_cnt  (beat_cnt),
        .pkt_cnt   (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each payload byte k holds tag^k, so slice misplacement is visible.
    function automatic logic [191:0] pl(input logic [7:0] tag);
        logic [191:0] r;
        for (int k = 0; k < 24; k++) r[8*k +: 8] = tag ^ 8'(k);
        return r;
    endfunction

    function automatic logic [200:0] mkw(input logic [1:0] ph, input logic nw, input logic lst,
                                         input logic [4:0] c, input logic [191:0] p);
        return {p, c, ph, lst, nw};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until it is popped (bounded wait).
    task automatic send(input logic [200:0] w);
        int waited;
        waited    = 0;
        din       = w;
        din_valid = 1'b1;
        #1;
        while (!rinc && waited < 16) begin
            step();
            waited++;
        end
        check_val("pop_seen", 256'(rinc), 256'(1));
        step();
        din_valid = 1'b0;
        din       = '0;
    endtask

    logic [191:0] a, b, c, d, e, f, g, h, i_, j, k_, l, m, n, o, p, q, r, s, t;
    logic [255:0] held;

    initial begin
        n_vec = 0;
        n_err = 0;
        a = pl(8'h10); b = pl(8'h20); c = pl(8'h30); d = pl(8'h40);
        e = pl(8'h50); f = pl(8'h60); g = pl(8'h70); h = pl(8'h80);
        i_ = pl(8'h90); j = pl(8'hA0); k_ = pl(8'hB0); l = pl(8'hC0);
        m = pl(8'hD0); n = pl(8'hE0); o = pl(8'hF0); p = pl(8'h11);
        q = pl(8'h22); r = pl(8'h33); s = pl(8'h44); t = pl(8'h55);

        // Reset: pop must stay low even with a word offered.
        reset     = 1'b1;
        m_tready  = 1'b0;
        din       = mkw(2'd0, 1'b1, 1'b0, 5'd0, a);
        din_valid = 1'b1;
        step();
        step();
        check_val("rst_rinc", 256'(rinc), 256'(0));
        check_val("rst_tvalid", 256'(m_tvalid), 256'(0));
        check_val("rst_tdata", m_tdata, 256'(0));
        check_val("rst_tstrb", 256'(m_tstrb), 256'(0));
        check_val("rst_tkeep", 256'(m_tkeep), 256'(0));
        check_val("rst_tlast", 256'(m_tlast), 256'(0));
        check_val("rst_sync_err", 256'(sync_err), 256'(0));
        check_val("rst_beat_cnt", 256'(beat_cnt), 256'(0));
        check_val("rst_pkt_cnt", 256'(pkt_cnt), 256'(0));
        din_valid = 1'b0;
        din       = '0;
        reset     = 1'b0;
        m_tready  = 1'b1;
        step();

        // Full four-phase packet.
        send(mkw(2'd0, 1'b1, 1'b0, 5'd0, a));
        check_val("p0_no_beat", 256'(m_tvalid), 256'(0));
        send(mkw(2'd1, 1'b1, 1'b0, 5'd0, b));
        check_val("b1_valid", 256'(m_tvalid), 256'(1));
        check_val("b1_data", m_tdata, {b[63:0], a});
        check_val("b1_last", 256'(m_tlast), 256'(0));
        check_val("b1_strb", 256'(m_tstrb), 256'(32'hFFFF_FFFF));
        check_val("b1_keep", 256'(m_tkeep), 256'(32'hFFFF_FFFF));
        send(mkw(2'd2, 1'b1, 1'b0, 5'd0, c));
        check_val("b2_valid", 256'(m_tvalid), 256'(1));
        check_val("b2_data", m_tdata, {c[127:0], b[191:64]});
        check_val("b2_last", 256'(m_tlast), 256'(0));
        send(mkw(2'd3, 1'b0, 1'b1, 5'd0, d));
        check_val("b3_data", m_tdata, {d, c[191:128]});
        check_val("b3_last", 256'(m_tlast), 256'(1));
        check_val("b3_strb", 256'(m_tstrb), 256'(32'hFFFF_FFFF));
        step();
        check_val("pkt1_idle", 256'(m_tvalid), 256'(0));
        check_val("pkt1_beat_cnt", 256'(beat_cnt), 256'(3));
        check_val("pkt1_pkt_cnt", 256'(pkt_cnt), 256'(1));

        // Short packet: P1 without new ends it with 5 valid bytes.
        send(mkw(2'd0, 1'b1, 1'b0, 5'd0, e));
        send(mkw(2'd1, 1'b0, 1'b1, 5'd5, f));
        check_val("short_data", m_tdata, {f[63:0], e});
        check_val("short_strb", 256'(m_tstrb), 256'(32'h0000_001F));
        check_val("short_keep", 256'(m_tkeep), 256'(32'h0000_001F));
        check_val("short_last", 256'(m_tlast), 256'(1));
        step();
        send(mkw(2'd0, 1'b1, 1'b0, 5'd0, g));
        check_val("short_resync_ok", 256'(sync_err), 256'(0));

        // Backpressure: beat held for 4 cycles, and the next word waits.
        m_tready = 1'b0;
        send(mkw(2'd1, 1'b1, 1'b0, 5'd0, h));
        held      = {h[63:0], g};
        din       = mkw(2'd2, 1'b1, 1'b0, 5'd0, i_);
        din_valid = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            check_val("bp_rinc", 256'(rinc), 256'(0));
            check_val("bp_valid", 256'(m_tvalid), 256'(1));
            check_val("bp_data", m_tdata, held);
            @(posedge clk);
            #0;
        end
        #1;
        m_tready = 1'b1;
        #1;
        check_val("bp_release_rinc", 256'(rinc), 256'(1));
        step();
        din_valid = 1'b0;
        din       = '0;
        check_val("bp_nobubble_valid", 256'(m_tvalid), 256'(1));
        check_val("bp_nobubble_data", m_tdata, {i_[127:0], h[191:64]});
        send(mkw(2'd3, 1'b0, 1'b1, 5'd0, j));
        check_val("bp_b3_data", m_tdata, {j, i_[191:128]});
        step();
        check_val("bp_beat_cnt", 256'(beat_cnt), 256'(7));
        check_val("bp_pkt_cnt", 256'(pkt_cnt), 256'(3));

        // Phase error: P2 after P0 is dropped. Later P1/P3 are dropped until P0.
        send(mkw(2'd0, 1'b1, 1'b0, 5'd0, k_));
        send(mkw(2'd2, 1'b1, 1'b0, 5'd0, l));
        check_val("err_sync", 256'(sync_err), 256'(1));
        check_val("err_no_beat", 256'(m_tvalid), 256'(0));
        send(mkw(2'd1, 1'b1, 1'b0, 5'd0, m));
        check_val("err_drop_p1", 256'(m_tvalid), 256'(0));
        send(mkw(2'd3, 1'b0, 1'b1, 5'd0, n));
        check_val("err_drop_p3", 256'(m_tvalid), 256'(0));
        send(mkw(2'd0, 1'b1, 1'b0, 5'd0, o));
        send(mkw(2'd1, 1'b0, 1'b1, 5'd0, p));
        check_val("err_resume_data", m_tdata, {p[63:0], o});
        check_val("err_resume_last", 256'(m_tlast), 256'(1));
        step();
        check_val("err_beat_cnt", 256'(beat_cnt), 256'(8));

        // Reset while a beat is held, then P2 is out of sync.
        send(mkw(2'd0, 1'b1, 1'b0, 5'd0, q));
        m_tready = 1'b0;
        send(mkw(2'd1, 1'b1, 1'b0, 5'd0, r));
        check_val("mid_held", 256'(m_tvalid), 256'(1));
        reset = 1'b1;
        step();
        check_val("mid_rst_valid", 256'(m_tvalid), 256'(0));
        check_val("mid_rst_beat_cnt", 256'(beat_cnt), 256'(0));
        check_val("mid_rst_pkt_cnt", 256'(pkt_cnt), 256'(0));
        check_val("mid_rst_sync_err", 256'(sync_err), 256'(0));
        reset    = 1'b0;
        m_tready = 1'b1;
        send(mkw(2'd2, 1'b1, 1'b0, 5'd0, s));
        check_val("mid_p2_sync_err", 256'(sync_err), 256'(1));
        check_val("mid_p2_no_beat", 256'(m_tvalid), 256'(0));

        // Counter wrap over 16 short packets. The first uses cnt=1 and the last uses cnt=31.
        for (int pk = 0; pk < 15; pk++) begin
            send(mkw(2'd0, 1'b1, 1'b0, 5'd0, t));
            send(mkw(2'd1, 1'b0, 1'b1, (pk == 0) ? 5'd1 : 5'd0, t));
            if (pk == 0) check_val("strb_cnt1", 256'(m_tstrb), 256'(32'h0000_0001));
            step();
        end
        check_val("wrap_pre_beat", 256'(beat_cnt), 256'(15));
        check_val("wrap_pre_pkt", 256'(pkt_cnt), 256'(15));
        send(mkw(2'd0, 1'b1, 1'b0, 5'd0, t));
        send(mkw(2'd1, 1'b0, 1'b1, 5'd31, t));
        check_val("strb_cnt31", 256'(m_tstrb), 256'(32'h7FFF_FFFF));
        step();
        check_val("wrap_beat", 256'(beat_cnt), 256'(0));
        check_val("wrap_pkt", 256'(pkt_cnt), 256'(0));
        check_val("sync_err_sticky", 256'(sync_err), 256'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
